// File: rtl/monolith_bricks.sv
// Monolith-31 Bricks layer: y[0]=x[0], y[i]=x[i]+x[i-1]^2 mod 2^31-1, NUM_SQ squarers time-multiplexed.
// Optional MONOLITH_BRICKS_BYPASS_EN adds a 'bypass' input that skips the squaring pass.
`timescale 1ns/1ps

module monolith_bricks_lane #(
  parameter int W = 31
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  localparam logic [W-1:0] P = '1;

  // One Mersenne fold of a W+1 bit value, result canonical in [0, P-1].
  function automatic logic [W-1:0] fold(input logic [W:0] s);
    logic [W-1:0] r;
    r = s[W-1:0] + {{(W-1){1'b0}}, s[W]};
    return (r == P) ? '0 : r;
  endfunction

  logic [2*W-1:0] sq;
  logic [W-1:0]   r;

  assign sq = {{W{1'b0}}, b} * {{W{1'b0}}, b};
  assign r  = fold({1'b0, sq[W-1:0]} + {1'b0, sq[2*W-1:W]});
  assign y  = fold({1'b0, a} + {1'b0, r});
endmodule

module monolith_bricks #(
  parameter int WORD_WIDTH = 31,
  parameter int STATE_SIZE = 16,
  parameter int NUM_SQ     = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_in,
`ifdef MONOLITH_BRICKS_BYPASS_EN
  input  logic                                  bypass,
`endif
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_out
);
  localparam int G  = STATE_SIZE / NUM_SQ;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [WORD_WIDTH-1:0] P = '1;

  generate
    if (WORD_WIDTH != 31) begin : g_bad_width
      $error("monolith_bricks: WORD_WIDTH must be 31");
    end
    if (NUM_SQ < 1 || (STATE_SIZE % NUM_SQ) != 0) begin : g_bad_sq
      $error("monolith_bricks: NUM_SQ must divide STATE_SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                                state, nxt;
  logic [GW-1:0]                         g;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] x_reg;
  logic [NUM_SQ-1:0][WORD_WIDTH-1:0]     lane_a, lane_b, lane_y;
  logic                                  byp;

`ifdef MONOLITH_BRICKS_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = byp ? DONE : BUSY;
      end
      BUSY: if (g == GW'(G - 1)) nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Lanes always read the captured x_reg, so lane i never sees an updated y[i-1].
  always_comb begin
    for (int k = 0; k < NUM_SQ; k++) begin
      lane_a[k] = x_reg[int'(g) * NUM_SQ + k];
      lane_b[k] = '0;
      if (int'(g) * NUM_SQ + k != 0) lane_b[k] = x_reg[int'(g) * NUM_SQ + k - 1];
    end
  end

  generate
    for (genvar k = 0; k < NUM_SQ; k++) begin : g_lane
      monolith_bricks_lane #(.W(WORD_WIDTH)) u_lane (
        .a (lane_a[k]),
        .b (lane_b[k]),
        .y (lane_y[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_reg     <= '0;
      state_out <= '0;
      g         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_reg <= state_in;
          g     <= '0;
          if (byp)
            for (int i = 0; i < STATE_SIZE; i++)
              state_out[i] <= (state_in[i] == P) ? '0 : state_in[i];
        end
        BUSY: begin
          for (int k = 0; k < NUM_SQ; k++)
            state_out[int'(g) * NUM_SQ + k] <= lane_y[k];
          g <= g + GW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
